// File: rtl/counter_5b_pkg.sv
// -----------------------------------------------------------------------------
// counter_5b_pkg
// Shared constants and types for the counter_5b block.
//   COUNTER_5B_WIDTH : default counter width (5 bits)
//   DIR_UP / DIR_DOWN: encodings of the up_down input
//   count_t          : count word at the default width
// Optional feature macro used by the block: COUNTER_5B_TC_EN
// -----------------------------------------------------------------------------
package counter_5b_pkg;

   localparam int COUNTER_5B_WIDTH = 5;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef logic [COUNTER_5B_WIDTH-1:0] count_t;

endpackage : counter_5b_pkg

// File: rtl/counter_5b_next.sv
// -----------------------------------------------------------------------------
// counter_5b_next
// Combinational next-count logic for counter_5b. Counting wraps naturally
// modulo 2^WIDTH because the arithmetic is kept at WIDTH bits.
// Ports:
//   i_count   [WIDTH-1:0] in  : current count
//   i_enable              in  : 1 = step, 0 = hold
//   i_up_down             in  : DIR_UP = increment, DIR_DOWN = decrement
//   o_next    [WIDTH-1:0] out : count to load on the next rising edge
// -----------------------------------------------------------------------------
module counter_5b_next
   import counter_5b_pkg::*;
#(
   parameter int WIDTH = COUNTER_5B_WIDTH
) (
   input  logic [WIDTH-1:0] i_count,
   input  logic             i_enable,
   input  logic             i_up_down,
   output logic [WIDTH-1:0] o_next
);

   logic [WIDTH-1:0] w_next;

   always_comb begin
      w_next = i_count;
      if (i_enable) begin
         if (i_up_down == DIR_UP) begin
            w_next = i_count + WIDTH'(1);
         end else begin
            w_next = i_count - WIDTH'(1);
         end
      end
   end

   assign o_next = w_next;

endmodule : counter_5b_next

// File: rtl/counter_5b.sv
// -----------------------------------------------------------------------------
// counter_5b
// Up/down wrapping counter with enable and asynchronous active-high reset.
// The count register drives the output directly (no output pipeline).
// Ports:
//   clock                       in  : rising-edge clock
//   reset                       in  : asynchronous, active-high; clears count
//   enable                      in  : 1 = count on next edge, 0 = hold
//   up_down                     in  : 1 = increment, 0 = decrement
//   counter        [WIDTH-1:0]  out : current count
//   terminal_count              out : only with COUNTER_5B_TC_EN; high when
//                                     the next enabled edge wraps the count
// Parameter WIDTH: 2..16, default 5.
// Macro COUNTER_5B_TC_EN: adds the terminal_count port and its logic.
// -----------------------------------------------------------------------------
module counter_5b
   import counter_5b_pkg::*;
#(
   parameter int WIDTH = COUNTER_5B_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_down,
`ifdef COUNTER_5B_TC_EN
   output logic             terminal_count,
`endif
   output logic [WIDTH-1:0] counter
);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_next;

   counter_5b_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .i_count   (r_count),
      .i_enable  (enable),
      .i_up_down (up_down),
      .o_next    (w_next)
   );

   // The async clear also suppresses any edge that arrives while reset is high.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_next;
      end
   end

   assign counter = r_count;

`ifdef COUNTER_5B_TC_EN
   logic w_at_max;
   logic w_at_min;

   assign w_at_max = (r_count == {WIDTH{1'b1}});
   assign w_at_min = (r_count == '0);

   // Gated by reset so the flag is low while the block is held in reset,
   // even though the count sits at 0 and a down request would otherwise flag.
   assign terminal_count = ~reset & enable &
                           (((up_down == DIR_UP)   & w_at_max) |
                            ((up_down == DIR_DOWN) & w_at_min));
`endif

endmodule : counter_5b

// File: tb/tb_counter_5b.sv
// -----------------------------------------------------------------------------
// tb_counter_5b
// Directed bench for counter_5b at the default width. Inputs change 1 ns after
// each rising edge; outputs are sampled at the same point, after the edge.
// -----------------------------------------------------------------------------
module tb_counter_5b;
   import counter_5b_pkg::*;

   localparam int W = 5;

   logic         clock = 1'b0;
   logic         reset;
   logic         enable;
   logic         up_down;
   logic [W-1:0] counter;
`ifdef COUNTER_5B_TC_EN
   logic         terminal_count;
`endif

   int n_checks = 0;
   int n_bad    = 0;

   count_t exp_q[$];

   counter_5b #(
      .WIDTH (W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .up_down        (up_down),
`ifdef COUNTER_5B_TC_EN
      .terminal_count (terminal_count),
`endif
      .counter        (counter)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      enable = 1'b0;
      step();
      reset  = 1'b0;
   endtask

   task automatic run_edges(input int n, input logic en, input logic dir);
      enable  = en;
      up_down = dir;
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      // Before the first clock edge: reset alone must clear the count.
      n_checks++;
      if (counter !== 5'd0) begin
         n_bad++;
         $display("FAIL reset_no_clock: got %0d expected 0", counter);
      end
      step();
      n_checks++;
      if (counter !== 5'd0) begin
         n_bad++;
         $display("FAIL reset_held: got %0d expected 0", counter);
      end
      reset = 1'b0;
      run_edges(7, 1'b1, DIR_UP);
      n_checks++;
      if (counter !== 5'd7) begin
         n_bad++;
         $display("FAIL reach_7: got %0d expected 7", counter);
      end
      // Assert reset between edges with enable still high.
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (counter !== 5'd0) begin
         n_bad++;
         $display("FAIL reset_async_mid: got %0d expected 0", counter);
      end
      step();
      n_checks++;
      if (counter !== 5'd0) begin
         n_bad++;
         $display("FAIL reset_edge_ignored: got %0d expected 0", counter);
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (counter !== 5'd1) begin
         n_bad++;
         $display("FAIL reset_resume: got %0d expected 1", counter);
      end
   endtask

   task automatic test_up_sweep();
      do_reset();
      for (int i = 1; i <= 32; i++) exp_q.push_back(count_t'(i % 32));
      enable  = 1'b1;
      up_down = DIR_UP;
      while (exp_q.size() > 0) begin
         count_t e;
         step();
         e = exp_q.pop_front();
         n_checks++;
         if (counter !== e) begin
            n_bad++;
            $display("FAIL up_sweep: got %0d expected %0d", counter, e);
         end
      end
   endtask

   task automatic test_down_sweep();
      do_reset();
      for (int i = 1; i <= 32; i++) exp_q.push_back(count_t'((32 - i) % 32));
      enable  = 1'b1;
      up_down = DIR_DOWN;
      while (exp_q.size() > 0) begin
         count_t e;
         step();
         e = exp_q.pop_front();
         n_checks++;
         if (counter !== e) begin
            n_bad++;
            $display("FAIL down_sweep: got %0d expected %0d", counter, e);
         end
      end
   endtask

   task automatic test_hold();
      do_reset();
      run_edges(12, 1'b1, DIR_UP);
      n_checks++;
      if (counter !== 5'd12) begin
         n_bad++;
         $display("FAIL hold_setup: got %0d expected 12", counter);
      end
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         up_down = logic'(i % 2);
         step();
         n_checks++;
         if (counter !== 5'd12) begin
            n_bad++;
            $display("FAIL hold: got %0d expected 12", counter);
         end
      end
      run_edges(1, 1'b1, DIR_UP);
      n_checks++;
      if (counter !== 5'd13) begin
         n_bad++;
         $display("FAIL hold_resume: got %0d expected 13", counter);
      end
   endtask

   task automatic test_reversal();
      logic         dirs [4];
      logic [W-1:0] exps [4];
      dirs = '{DIR_UP, DIR_UP, DIR_DOWN, DIR_DOWN};
      exps = '{5'd6, 5'd7, 5'd6, 5'd5};
      do_reset();
      run_edges(5, 1'b1, DIR_UP);
      for (int i = 0; i < 4; i++) begin
         up_down = dirs[i];
         step();
         n_checks++;
         if (counter !== exps[i]) begin
            n_bad++;
            $display("FAIL reversal_%0d: got %0d expected %0d", i, counter, exps[i]);
         end
      end
   endtask

`ifdef COUNTER_5B_TC_EN
   task automatic test_terminal_count();
      // 31 reached by one down step from 0.
      do_reset();
      run_edges(1, 1'b1, DIR_DOWN);
      enable  = 1'b1;
      up_down = DIR_UP;
      #1;
      n_checks++;
      if (terminal_count !== 1'b1) begin
         n_bad++;
         $display("FAIL tc_max_up: got %0b expected 1 (count %0d)", terminal_count, counter);
      end
      enable = 1'b0;
      #1;
      n_checks++;
      if (terminal_count !== 1'b0) begin
         n_bad++;
         $display("FAIL tc_max_disabled: got %0b expected 0", terminal_count);
      end
      enable  = 1'b1;
      up_down = DIR_DOWN;
      #1;
      n_checks++;
      if (terminal_count !== 1'b0) begin
         n_bad++;
         $display("FAIL tc_max_down: got %0b expected 0", terminal_count);
      end
      // Held in reset with a down request: flag must stay low.
      reset = 1'b1;
      #1;
      n_checks++;
      if (terminal_count !== 1'b0) begin
         n_bad++;
         $display("FAIL tc_in_reset: got %0b expected 0", terminal_count);
      end
      step();
      reset = 1'b0;
      #1;
      n_checks++;
      if (terminal_count !== 1'b1) begin
         n_bad++;
         $display("FAIL tc_min_down: got %0b expected 1", terminal_count);
      end
      enable = 1'b0;
      #1;
      n_checks++;
      if (terminal_count !== 1'b0) begin
         n_bad++;
         $display("FAIL tc_min_disabled: got %0b expected 0", terminal_count);
      end
      enable  = 1'b1;
      up_down = DIR_UP;
      #1;
      n_checks++;
      if (terminal_count !== 1'b0) begin
         n_bad++;
         $display("FAIL tc_min_up: got %0b expected 0", terminal_count);
      end
   endtask
`endif

   // ---------------- sequence + report ----------------
   initial begin
      reset   = 1'b1;
      enable  = 1'b0;
      up_down = DIR_UP;
      #3;
      test_reset();
      test_up_sweep();
      test_down_sweep();
      test_hold();
      test_reversal();
`ifdef COUNTER_5B_TC_EN
      test_terminal_count();
`endif
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule : tb_counter_5b

// File: doc/counter_5b.md
COUNTER_5B -- requirements
Module: counter_5b

Interface
REQ-001 Parameter: WIDTH, default 5, counter width in bits; legal range 2..16.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: enable  input  1  1 = count on the next rising edge; 0 = hold.
REQ-005 Port: up_down  input  1  1 = increment; 0 = decrement.
REQ-006 Port: counter  output  WIDTH  current count, driven directly from a register.
REQ-007 Port (only with COUNTER_5B_TC_EN): terminal_count  output  1  terminal-count flag.

Function
REQ-008 The count SHALL change only on a rising clock edge while reset is low.
REQ-009 On an edge with enable=1 and up_down=1, counter SHALL become counter+1 modulo 2^WIDTH.
REQ-010 On an edge with enable=1 and up_down=0, counter SHALL become counter-1 modulo 2^WIDTH.
REQ-011 Up-count wrap: 31 -> 0 (WIDTH=5); no flag other than REQ-019, no stall.
REQ-012 Down-count wrap: 0 -> 31 (WIDTH=5).
REQ-013 On an edge with enable=0, counter SHALL hold its value regardless of up_down.
REQ-014 up_down and enable are sampled on each edge only; a direction change takes effect on the first edge after it, with no extra-cycle penalty and no lost step.
REQ-015 Latency: counter SHALL reflect the new value within the same cycle as the active edge (one register stage, no output pipeline).
REQ-016 Inputs are synchronous to clock; the block contains no input synchronisers.

Reset
REQ-017 While reset=1, counter SHALL be 0, applied asynchronously with no clock required; terminal_count SHALL be 0.
REQ-018 On reset deassertion, counting SHALL resume at the first rising edge on which reset is low, starting from 0. Reset asserted mid-count SHALL clear counter immediately, and the edge concurrent with reset SHALL be ignored.

Configuration
REQ-019 Macro COUNTER_5B_TC_EN: when defined, terminal_count SHALL be a combinational output equal to 1 when enable=1 and either (up_down=1 and counter=2^WIDTH-1) or (up_down=0 and counter=0), i.e. when the next edge wraps.
REQ-020 When COUNTER_5B_TC_EN is undefined, the terminal_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 Package counter_5b_pkg SHALL hold the WIDTH default constant, direction constants DIR_UP=1 and DIR_DOWN=0, and a count typedef of width WIDTH.
REQ-022 One sub-module, counter_5b_next, SHALL compute the next count combinationally from (count, enable, up_down). counter_5b SHALL hold only the register and the optional terminal_count logic.

Verification
REQ-023 Reset check: assert reset=1 between clock edges with count=7 -> counter=0 immediately, before any edge; it stays 0 while reset is held.
REQ-024 Full up sweep: enable=1, up_down=1, 32 edges from 0 -> counter goes 1,2,...,31,0 with no skipped values.
REQ-025 Full down sweep: up_down=0, 32 edges from 0 -> counter goes 31,30,...,1,0.
REQ-026 Hold check: count=12, enable=0 for 5 edges, toggling up_down -> counter stays 12, and resumes at 13 on the next enabled up edge.
REQ-027 Direction reversal: count=5, then up, up, down, down -> counter goes 6,7,6,5.
REQ-028 With COUNTER_5B_TC_EN: count=31 with up, or count=0 with down, enable=1 -> terminal_count=1; enable=0 -> terminal_count=0.
